// File: rtl/linear_stream_feeder.sv
// Buffers NUM_FEATURES activation rows, then issues one chunk beat per (neuron, chunk) with
// ROM weights/bias aligned to registered features; m_ce trails each issue by one cycle.
module linear_stream_feeder #(
  parameter int PRECISION      = 8,
  parameter int BIAS_PRECISION = 32,
  parameter int NUM_FEATURES   = 2,
  parameter int N              = 16,
  parameter int IN_DIM         = 64,
  parameter int OUT_DIM        = 10,
  localparam int CHUNKS        = IN_DIM / N,
  localparam int WA_W          = (OUT_DIM * CHUNKS > 1) ? $clog2(OUT_DIM * CHUNKS) : 1,
  localparam int BA_W          = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  input  logic [N-1:0][PRECISION-1:0]                   s_data,
  input  logic                                          s_last,
  output logic [WA_W-1:0]                               w_addr,
  input  logic [N-1:0][PRECISION-1:0]                   w_rd_data,
  output logic [BA_W-1:0]                               b_addr,
  input  logic [BIAS_PRECISION-1:0]                     b_rd_data,
  input  logic                                          m_ready,
  output logic                                          m_ce,
  output logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] m_features,
  output logic [N-1:0][PRECISION-1:0]                   m_weights,
  output logic [BIAS_PRECISION-1:0]                     m_bias,
  output logic                                          m_first,
  output logic                                          m_last,
  output logic [BA_W-1:0]                               m_neuron,
  output logic                                          done,
  output logic                                          err
);

  if (IN_DIM % N != 0) begin : g_bad_dim
    $error("IN_DIM must be a multiple of N");
  end

  localparam int RW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [RW-1:0]   R_LAST = RW'(NUM_FEATURES - 1);
  localparam logic [CW-1:0]   C_LAST = CW'(CHUNKS - 1);
  localparam logic [BA_W-1:0] O_LAST = BA_W'(OUT_DIM - 1);

  typedef enum logic [1:0] {LOAD, STREAM, DRAIN} state_t;

  state_t                     state, nxt;
  logic [RW-1:0]              ld_row;
  logic [CW-1:0]              ld_col;
  logic [CW-1:0]              c;
  logic [BA_W-1:0]            o;
  logic [WA_W-1:0]            wa;
  logic [N-1:0][PRECISION-1:0] act_buf [NUM_FEATURES][CHUNKS];

  logic accept, ld_final, issue, pass_end;

  assign accept   = s_valid && s_ready;
  assign ld_final = (ld_row == R_LAST) && (ld_col == C_LAST);
  assign issue    = (state == STREAM) && m_ready;
  assign pass_end = (c == C_LAST) && (o == O_LAST);

  assign w_addr    = wa;
  assign b_addr    = o;
  assign m_weights = w_rd_data;
  assign m_bias    = b_rd_data;

  always_comb begin
    nxt  = state;
    done = 1'b0;
    case (state)
      LOAD:    if (accept && ld_final) nxt = STREAM;
      STREAM:  if (issue && pass_end) nxt = DRAIN;
      DRAIN: begin
        done = 1'b1;
        nxt  = LOAD;
      end
      default: nxt = LOAD;
    endcase
  end

  // s_ready is registered from the next state so it stays low through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= LOAD;
      s_ready <= 1'b0;
    end else begin
      state   <= nxt;
      s_ready <= (nxt == LOAD);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_row <= '0;
      ld_col <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      if (s_last != ld_final) err <= 1'b1;
      if (ld_col == C_LAST) begin
        ld_col <= '0;
        ld_row <= ld_final ? '0 : ld_row + 1'b1;
      end else begin
        ld_col <= ld_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) act_buf[ld_row][ld_col] <= s_data;
  end

  // Weight address runs linearly through o*CHUNKS+c, so a plain counter suffices.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c          <= '0;
      o          <= '0;
      wa         <= '0;
      m_ce       <= 1'b0;
      m_first    <= 1'b0;
      m_last     <= 1'b0;
      m_neuron   <= '0;
      m_features <= '0;
    end else begin
      m_ce <= issue;
      if (issue) begin
        for (int f = 0; f < NUM_FEATURES; f++) m_features[f] <= act_buf[f][c];
        m_first  <= (c == '0);
        m_last   <= (c == C_LAST);
        m_neuron <= o;
        if (pass_end) wa <= '0;
        else          wa <= wa + 1'b1;
        if (c == C_LAST) begin
          c <= '0;
          o <= (o == O_LAST) ? '0 : o + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_linear_stream_feeder.sv
// Scoreboard bench: each load pushes the 40 beats a pass must produce; a negedge monitor pops and compares.
module tb_linear_stream_feeder;
  localparam int P = 8, BP = 32, NF = 2, N = 16, IN = 64, OUT = 10;
  localparam int CH = IN / N, TOT = NF * CH, WA_W = 6, BA_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_ready, s_last;
  logic [N-1:0][P-1:0] s_data;
  logic [WA_W-1:0] w_addr;
  logic [N-1:0][P-1:0] w_rd_data;
  logic [BA_W-1:0] b_addr;
  logic [BP-1:0] b_rd_data;
  logic m_ready, m_ce, m_first, m_last, done, err;
  logic [NF-1:0][N-1:0][P-1:0] m_features;
  logic [N-1:0][P-1:0] m_weights;
  logic [BP-1:0] m_bias;
  logic [BA_W-1:0] m_neuron;

  always #5 clk = ~clk;

  linear_stream_feeder dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .w_addr(w_addr), .w_rd_data(w_rd_data), .b_addr(b_addr), .b_rd_data(b_rd_data),
    .m_ready(m_ready), .m_ce(m_ce), .m_features(m_features), .m_weights(m_weights), .m_bias(m_bias),
    .m_first(m_first), .m_last(m_last), .m_neuron(m_neuron), .done(done), .err(err)
  );

  // External ROMs: weight ROM returns its address in every lane, bias ROM returns 1000+address.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) w_rd_data[i] <= P'(w_addr);
    b_rd_data <= 1000 + BP'(b_addr);
  end

  typedef struct {
    logic [NF-1:0][N-1:0][P-1:0] feat;
    logic [N-1:0][P-1:0]         w;
    logic [BP-1:0]               b;
    logic                        first, last, dn;
    logic [BA_W-1:0]             neuron;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   rows [NF][IN];
  int   checks = 0, passed = 0;
  int   beats_in_pass = 0, passes = 0, first_cyc = 0, cyc_cnt = 0;
  bit   sready_next = 0, contig_mode = 0;

  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  // mode 0: element = beat*16+lane; mode 1: random bytes with random s_valid gaps.
  task automatic load_pass(input int mode, input int bad_beat, input bit drop_final_last, output int rdy_cycles);
    int k, cyc;
    bit acc;
    exp_t e;
    for (int b = 0; b < TOT; b++)
      for (int l = 0; l < N; l++)
        rows[b / CH][(b % CH) * N + l] = (mode == 0) ? ((b * 16 + l) & 255) : int'($urandom_range(0, 255));
    k = 0; cyc = 0; rdy_cycles = 0;
    while (k < TOT && cyc < 500) begin
      s_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int l = 0; l < N; l++) s_data[l] = P'(rows[k / CH][(k % CH) * N + l]);
      s_last = (k == TOT - 1) ? !drop_final_last : (k == bad_beat);
      @(negedge clk);
      acc = s_valid && s_ready;
      if (s_ready) rdy_cycles++;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk(k == TOT, "load_accepts", k, TOT);
    for (int o = 0; o < OUT; o++)
      for (int c = 0; c < CH; c++) begin
        for (int f = 0; f < NF; f++)
          for (int l = 0; l < N; l++) e.feat[f][l] = P'(rows[f][c * N + l]);
        for (int l = 0; l < N; l++) e.w[l] = P'(o * CH + c);
        e.b      = BP'(1000 + o);
        e.first  = (c == 0);
        e.last   = (c == CH - 1);
        e.dn     = (o == OUT - 1) && (c == CH - 1);
        e.neuron = BA_W'(o);
        sbq.push_back(e);
      end
  endtask

  task automatic wait_pass(input int start);
    int n = 0;
    while (passes == start && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(passes != start, "pass_complete", passes, start + 1);
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats_in_pass < target && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk(beats_in_pass >= target, "reach_beat", beats_in_pass, target);
  endtask

  task automatic reset_checks();
    chk(s_ready == 0, "rst_s_ready", s_ready, 0);
    chk(m_ce == 0, "rst_m_ce", m_ce, 0);
    chk(m_first == 0, "rst_m_first", m_first, 0);
    chk(m_last == 0, "rst_m_last", m_last, 0);
    chk(done == 0, "rst_done", done, 0);
    chk(err == 0, "rst_err", err, 0);
    chk(w_addr == 0, "rst_w_addr", w_addr, 0);
    chk(b_addr == 0, "rst_b_addr", b_addr, 0);
    chk(m_neuron == 0, "rst_m_neuron", m_neuron, 0);
    chk(m_features == '0, "rst_m_features", m_features, 0);
  endtask

  always @(negedge clk) begin
    cyc_cnt++;
    if (!rst) begin
      sbq.delete();
      beats_in_pass = 0;
      sready_next   = 0;
    end else begin
      if (sready_next) begin
        chk(s_ready == 1, "s_ready_after_done", s_ready, 1);
        sready_next = 0;
      end
      if (m_ce) begin
        if (beats_in_pass == 0) first_cyc = cyc_cnt;
        beats_in_pass++;
        if (sbq.size() == 0) begin
          chk(0, "unexpected_beat", m_neuron, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk(m_features == mon_e.feat, "m_features", m_features, mon_e.feat);
          chk(m_weights == mon_e.w, "m_weights", m_weights, mon_e.w);
          chk(m_bias == mon_e.b, "m_bias", m_bias, mon_e.b);
          chk({m_first, m_last, done} == {mon_e.first, mon_e.last, mon_e.dn}, "first_last_done",
              {m_first, m_last, done}, {mon_e.first, mon_e.last, mon_e.dn});
          chk(m_neuron == mon_e.neuron, "m_neuron", m_neuron, mon_e.neuron);
        end
        if (done) begin
          chk(beats_in_pass == OUT * CH, "beats_per_pass", beats_in_pass, OUT * CH);
          if (contig_mode) chk(cyc_cnt - first_cyc == OUT * CH - 1, "contiguous", cyc_cnt - first_cyc, OUT * CH - 1);
          passes++;
          beats_in_pass = 0;
          sready_next   = 1;
        end
      end else if (done) begin
        chk(0, "done_without_ce", done, 0);
      end
    end
  end

  initial begin
    int rc, start, snap, n;
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Pass 1: deterministic pattern, latency of the first beat.
    contig_mode = 1;
    start = passes;
    load_pass(0, -1, 0, rc);
    chk(rc == TOT, "s_ready_cycles", rc, TOT);
    chk(s_ready == 0, "s_ready_drop", s_ready, 0);
    chk(w_addr == 0, "first_w_addr", w_addr, 0);
    chk(m_ce == 0, "ce_not_yet", m_ce, 0);
    @(posedge clk); #1;
    chk(m_ce == 1, "first_ce_latency", m_ce, 1);
    chk(m_first == 1, "first_m_first", m_first, 1);
    wait_pass(start);
    chk(err == 0, "err_clean", err, 0);

    // Pass 2: random data, random downstream backpressure.
    contig_mode = 0;
    start = passes;
    load_pass(1, -1, 0, rc);
    n = 0;
    while (passes == start && n < 3000) begin
      m_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      n++;
    end
    m_ready = 1'b1;
    chk(passes != start, "random_ready_pass", passes, start + 1);

    // Pass 3: five-cycle stall near issue 13.
    start = passes;
    load_pass(1, -1, 0, rc);
    wait_beats(12);
    m_ready = 1'b0;
    snap = beats_in_pass;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk(beats_in_pass - snap <= 1, "stall_skid", beats_in_pass - snap, 1);
    m_ready = 1'b1;
    wait_pass(start);

    // Pass 4: s_last early on beat 5 and missing on the final beat.
    start = passes;
    load_pass(1, 5, 1, rc);
    wait_pass(start);
    chk(err == 1, "err_set", err, 1);

    // Pass 5: clean framing, err must remain set.
    start = passes;
    load_pass(1, -1, 0, rc);
    wait_pass(start);
    chk(err == 1, "err_sticky", err, 1);

    // Pass 6: reset in the middle of streaming.
    load_pass(1, -1, 0, rc);
    wait_beats(20);
    rst = 1'b0;
    #1;
    reset_checks();
    @(posedge clk); #1;
    reset_checks();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Pass 7: fresh load after the aborted pass.
    contig_mode = 1;
    start = passes;
    load_pass(0, -1, 0, rc);
    wait_pass(start);
    chk(err == 0, "err_after_reset", err, 0);
    repeat (3) @(posedge clk);
    #1;
    chk(sbq.size() == 0, "scoreboard_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/linear_stream_feeder.md
Name: linear_stream_feeder

Overview:
Front-end sequencer that produces the operand stream consumed by the linear-layer multiplier array. It buffers NUM_FEATURES activation rows arriving over a valid/ready stream, then fetches weights and bias from external synchronous ROMs. For each output neuron it issues the IN_DIM/N chunk beats that carry aligned features, weights, bias, ce and chunk-boundary flags. It sits between the activation input FIFO and the multiplier/accumulator/output-stage pipeline.

Parameters:
PRECISION, 8, activation/weight width in bits
BIAS_PRECISION, 32, bias width in bits
NUM_FEATURES, 2, parallel activation rows per pass
N, 16, elements per chunk (multiplier vector width)
IN_DIM, 64, elements per activation row; IN_DIM % N != 0 is an elaboration error
OUT_DIM, 10, output neurons per pass
Derived: CHUNKS = IN_DIM/N; WA_W = max(1, clog2(OUT_DIM*CHUNKS)); BA_W = max(1, clog2(OUT_DIM))

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
s_valid  in  1  activation beat valid
s_ready  out  1  feeder accepts a beat
s_data  in  [PRECISION-1:0] x N  one activation chunk
s_last  in  1  marks the final beat of a load
w_addr  out  WA_W  weight ROM address, 1-cycle read latency
w_rd_data  in  [PRECISION-1:0] x N  weight ROM data
b_addr  out  BA_W  bias ROM address, 1-cycle read latency
b_rd_data  in  BIAS_PRECISION  bias ROM data
m_ready  in  1  downstream may accept new issues
m_ce  out  1  operand beat valid (drives multiplier ce)
m_features  out  [PRECISION-1:0] x NUM_FEATURES x N  activation chunk per row
m_weights  out  [PRECISION-1:0] x N  equals w_rd_data (combinational)
m_bias  out  BIAS_PRECISION  equals b_rd_data (combinational)
m_first  out  1  beat is chunk 0 of the neuron
m_last  out  1  beat is chunk CHUNKS-1 of the neuron
m_neuron  out  BA_W  neuron index of the beat
done  out  1  one-cycle pulse at the end of a pass
err  out  1  sticky s_last framing error

Behaviour:
- Reset (rst=0, asynchronous): state LOAD; all counters 0; s_ready, m_ce, m_first, m_last, done and err = 0; m_features, w_addr, b_addr and m_neuron = 0. m_weights and m_bias follow the ROM data. Reset mid-pass discards the buffer and any in-flight beat.
- LOAD: s_ready=1. Beat k (0..NUM_FEATURES*CHUNKS-1) is written to buf[k/CHUNKS][k%CHUNKS] when s_valid&&s_ready.
  - s_last on a beat other than the final one, or missing on the final beat, sets err; the beat count alone decides the transition.
  - After the final beat is accepted, the next state is STREAM and s_ready drops in the following cycle.
- STREAM: s_ready=0. An issue occurs in any cycle with m_ready=1. Indices advance (c, then o).
  - An issue drives w_addr=o*CHUNKS+c and b_addr=o. The same cycle registers buf[*][c] into m_features, plus flags and m_neuron=o.
  - m_ce=1 exactly one cycle after each issue, aligned with the ROM data. Latency from issue to m_ce is 1.
  - m_ready=0 stalls issuing; addresses hold; the beat already in flight still appears. Downstream must absorb at most 1 beat after deasserting m_ready.
  - After issue (o=OUT_DIM-1, c=CHUNKS-1) the next state is DRAIN.
- DRAIN (1 cycle): final beat shows m_ce=1, m_last=1 and done=1 in this cycle. Next state is LOAD, and s_ready=1 the cycle after.
- m_ce=0 in every cycle that does not follow an issue. m_first, m_last and m_neuron are don't-care when m_ce=0 but are held registered.
- err clears only on reset.

Test Plan:
- Defaults; 8 beats, element values = beat*16+lane, s_valid held high → s_ready high for 8 cycles. First m_ce 2 cycles after the 8th accept, with m_features[0] = beat0, m_features[1] = beat4, w_addr=0, m_first=1.
- Full pass with m_ready=1 → exactly 40 m_ce beats, contiguous. m_last on beats 3,7,…,39. m_neuron steps 0..9. done coincides with beat 40. s_ready reasserts the next cycle.
- Weight ROM model returning addr in every lane, bias ROM returning 1000+o → each beat has m_weights = o*4+c and m_bias = 1000+o.
- m_ready low for 5 cycles at issue 13 → at most 1 beat after the drop, no beat is lost or duplicated, and 40 beats total in order.
- s_last asserted on beat 5 and not on beat 7 → err=1; the pass still runs with 40 beats; err stays 1 until rst.
- rst low during issue 20, then released and a new 8-beat load applied → all outputs are 0 during reset, and the new pass emits 40 beats starting at neuron 0.
